// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full subtractor (two half subtractors plus a borrow flop)
// processes a - b LSB first, sequenced by an IDLE/RUN/DONE FSM with a start/busy/done handshake.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake: start is sampled only in IDLE; busy is high throughout RUN;
    // done pulses for exactly one cycle while diff/borrow_out become valid.
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             ai, bi, d1, b1, di, b2, bout;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        ai   = a_sh_q[0];
        bi   = b_sh_q[0];
        d1   = ai ^ bi;
        b1   = ~ai & bi;
        di   = d1 ^ borrow_q;
        b2   = ~d1 & borrow_q;
        bout = b1 | b2;
        // New bit enters at the MSB so the LSB-first stream ends up in place.
        res_shift            = res_q >> 1;
        res_shift[WIDTH-1]   = di;
    end

    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_d        = res_q;
        cnt_d        = cnt_q;
        borrow_d     = borrow_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_d    = res_shift;
                borrow_d = bout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d      = DONE;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    diff_d       = res_shift;
                    borrow_out_d = bout;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_q        <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_q        <= res_d;
            cnt_q        <= cnt_d;
            borrow_q     <= borrow_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: WIDTH=8 and WIDTH=1 instances checked against an
// arithmetic (a - b) reference held in an expected queue.
module tb_serial_sub_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done, borrow_out;
    logic [7:0] diff;
    logic [1:0] state_dbg;

    logic       start1;
    logic [0:0] a1, b1;
    logic       busy1, done1, borrow_out1;
    logic [0:0] diff1;
    logic [1:0] state_dbg1;

    int checks   = 0;
    int failures = 0;
    logic [8:0] exp_q[$];

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out),
        .state_dbg(state_dbg)
    );

    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(borrow_out1),
        .state_dbg(state_dbg1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: modular difference plus unsigned compare, with a width parameter.
    function automatic logic [8:0] ref_sub(input int x, input int y, input int w);
        int m;
        m = 1 << w;
        ref_sub[7:0] = 8'(((x - y) % m + m) % m);
        ref_sub[8]   = (x < y);
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_op(input logic [7:0] av, input logic [7:0] bv);
        int n, busy_n;
        logic [8:0] e;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        exp_q.push_back(ref_sub(av, bv, 8));
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        n = 0; busy_n = 0;
        while (!done && n < 40) begin
            if (busy) busy_n++;
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("busy_cycles", busy_n, 32'd8);
        check("latency", n, 32'd8);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        e = exp_q.pop_front();
        check("diff", {24'd0, diff}, {24'd0, e[7:0]});
        check("borrow_out", {31'd0, borrow_out}, {31'd0, e[8]});
        @(negedge clk);
        check("done_pulse_len", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n1, n2, cnt;
        logic [8:0] e;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_borrow", {31'd0, borrow_out}, 32'd0);
        check("rst_done1", {31'd0, done1}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed operand pairs
        do_op(8'd200, 8'd55);
        check("dir_200_55", {24'd0, diff}, 32'd145);
        do_op(8'd5, 8'd9);
        check("dir_5_9", {23'd0, borrow_out, diff}, {23'd0, 1'b1, 8'd252});
        do_op(8'd170, 8'd170);
        check("dir_170_170", {23'd0, borrow_out, diff}, 32'd0);
        do_op(8'd0, 8'd255);
        check("dir_0_255", {23'd0, borrow_out, diff}, {23'd0, 1'b1, 8'd1});

        // start held high, operands changed mid-run
        @(negedge clk);
        a = 8'd200; b = 8'd55; start = 1'b1;
        @(negedge clk);
        a = 8'd5; b = 8'd9;
        wait_done(n1);
        check("held_lat", n1, 32'd8);
        check("held_diff1", {23'd0, borrow_out, diff}, {23'd0, ref_sub(200, 55, 8)});
        @(negedge clk);
        wait_done(n2);
        check("held_gap", n2 + 1, 32'd10);
        check("held_diff2", {23'd0, borrow_out, diff}, {23'd0, ref_sub(5, 9, 8)});
        start = 1'b0;
        @(negedge clk);
        check("held_done_pulse", {31'd0, done}, 32'd0);
        @(negedge clk);

        // asynchronous reset mid-run
        a = 8'd100; b = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_diff", {24'd0, diff}, 32'd0);
        check("arst_borrow", {31'd0, borrow_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("no_done_after_abort", cnt, 32'd0);
        do_op(8'd170, 8'd169);

        // random sweep
        for (int i = 0; i < 1000; i++)
            do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

        // WIDTH=1 instance, all operand pairs
        for (int x = 0; x < 2; x++) begin
            for (int y = 0; y < 2; y++) begin
                @(negedge clk);
                a1 = 1'(x); b1 = 1'(y); start1 = 1'b1;
                @(negedge clk);
                start1 = 1'b0;
                a1 = ~a1; b1 = ~b1;
                check("w1_busy", {31'd0, busy1}, 32'd1);
                check("w1_early_done", {31'd0, done1}, 32'd0);
                @(negedge clk);
                e = ref_sub(x, y, 1);
                check("w1_done", {31'd0, done1}, 32'd1);
                check("w1_diff", {31'd0, diff1}, {31'd0, e[0]});
                check("w1_borrow", {31'd0, borrow_out1}, {31'd0, e[8]});
                @(negedge clk);
                check("w1_done_pulse", {31'd0, done1}, 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
